// File: rtl/id_pipe_if.sv
// Instruction-decode stream bundle: IF->ID instruction handshake plus the
// registered ID/EX payload handshake. Signal names match the legacy ports.
interface id_pipe_if #(
  parameter int DATA_W = 32
);
  // IF -> ID
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  // ID -> EX
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [31:0]       pc_o;
  logic              inst_invalid_o;

  // Decode-stage view
  modport slave (
    input  in_valid, pc_i, inst_i, out_ready,
    output in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, inst_invalid_o
  );

  // Environment view (fetch side + execute side)
  modport master (
    output in_valid, pc_i, inst_i, out_ready,
    input  in_ready, out_valid, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, pc_o, inst_invalid_o
  );
endinterface

// File: rtl/id_pipe.sv
// Instruction decode stage: decodes logic-class MIPS instructions, reads and
// forwards operands, detects load-use hazards and registers the ID/EX payload
// behind a valid/ready handshake. Counts load-use stall cycles.
module id_pipe #(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  id_pipe_if.slave               bus,
  output logic                   reg1_read_o,
  output logic                   reg2_read_o,
  output logic [4:0]             reg1_addr_o,
  output logic [4:0]             reg2_addr_o,
  input  logic [DATA_W-1:0]      reg1_data_i,
  input  logic [DATA_W-1:0]      reg2_data_i,
  input  logic                   ex_wreg,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_wd,
  input  logic [DATA_W-1:0]      ex_wdata,
  input  logic                   mem_wreg,
  input  logic [4:0]             mem_wd,
  input  logic [DATA_W-1:0]      mem_wdata,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'b000000,
    OP_ANDI    = 6'b001100,
    OP_ORI     = 6'b001101,
    OP_XORI    = 6'b001110,
    OP_LUI     = 6'b001111
  } opcode_e;

  typedef enum logic [5:0] {
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_XOR = 6'b100110,
    FN_NOR = 6'b100111
  } funct_e;

  typedef enum logic [7:0] {
    ALU_NOP = 8'h00,
    ALU_AND = 8'h24,
    ALU_OR  = 8'h25,
    ALU_XOR = 8'h26,
    ALU_NOR = 8'h27
  } aluop_e;

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001
  } alusel_e;

  typedef struct packed {
    logic [7:0]        aluop;
    logic [2:0]        alusel;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [4:0]        wd;
    logic              wreg;
    logic [31:0]       pc;
    logic              inval;
  } payload_t;

  // Decode results for the currently offered instruction
  logic [7:0]        aluop_dec;
  logic [2:0]        alusel_dec;
  logic              r1_en;
  logic              r2_en;
  logic [4:0]        r1_addr;
  logic [4:0]        r2_addr;
  logic [4:0]        wd_dec;
  logic              wreg_dec;
  logic              inval_dec;
  logic [DATA_W-1:0] imm_dec;

  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic              hazard;
  logic              in_ready;
  logic              capture;

  logic                   out_valid_q, out_valid_d;
  payload_t               payload_q, payload_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Instruction decode: anything outside the supported set is flagged invalid
  always_comb begin
    aluop_dec  = ALU_NOP;
    alusel_dec = SEL_NOP;
    r1_en      = 1'b0;
    r2_en      = 1'b0;
    r1_addr    = bus.inst_i[25:21];
    r2_addr    = bus.inst_i[20:16];
    wd_dec     = '0;
    wreg_dec   = 1'b0;
    inval_dec  = 1'b1;
    imm_dec    = '0;
    if (bus.inst_i == '0) begin
      inval_dec = 1'b0;
    end else begin
      case (bus.inst_i[31:26])
        OP_ANDI, OP_ORI, OP_XORI: begin
          r1_en      = 1'b1;
          wd_dec     = bus.inst_i[20:16];
          wreg_dec   = 1'b1;
          inval_dec  = 1'b0;
          alusel_dec = SEL_LOGIC;
          imm_dec    = DATA_W'(bus.inst_i[15:0]);
          case (bus.inst_i[31:26])
            OP_ANDI: aluop_dec = ALU_AND;
            OP_ORI:  aluop_dec = ALU_OR;
            default: aluop_dec = ALU_XOR;
          endcase
        end
        OP_LUI: begin
          // Implemented as OR with $0, so port 1 always yields zero
          r1_en      = 1'b1;
          r1_addr    = '0;
          wd_dec     = bus.inst_i[20:16];
          wreg_dec   = 1'b1;
          inval_dec  = 1'b0;
          alusel_dec = SEL_LOGIC;
          aluop_dec  = ALU_OR;
          imm_dec    = DATA_W'({bus.inst_i[15:0], 16'h0000});
        end
        OP_SPECIAL: begin
          case (bus.inst_i[5:0])
            FN_AND, FN_OR, FN_XOR, FN_NOR: begin
              r1_en      = 1'b1;
              r2_en      = 1'b1;
              wd_dec     = bus.inst_i[15:11];
              wreg_dec   = 1'b1;
              inval_dec  = 1'b0;
              alusel_dec = SEL_LOGIC;
              case (bus.inst_i[5:0])
                FN_AND:  aluop_dec = ALU_AND;
                FN_OR:   aluop_dec = ALU_OR;
                FN_XOR:  aluop_dec = ALU_XOR;
                default: aluop_dec = ALU_NOR;
              endcase
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Operand selection with EX-over-MEM forwarding priority
  always_comb begin
    if (!r1_en)                                 op1 = '0;
    else if (r1_addr == '0)                     op1 = '0;
    else if (ex_wreg && (ex_wd == r1_addr))     op1 = ex_wdata;
    else if (mem_wreg && (mem_wd == r1_addr))   op1 = mem_wdata;
    else                                        op1 = reg1_data_i;

    if (!r2_en)                                 op2 = imm_dec;
    else if (r2_addr == '0)                     op2 = '0;
    else if (ex_wreg && (ex_wd == r2_addr))     op2 = ex_wdata;
    else if (mem_wreg && (mem_wd == r2_addr))   op2 = mem_wdata;
    else                                        op2 = reg2_data_i;
  end

  assign hazard = bus.in_valid & ex_is_load & ex_wreg & (ex_wd != '0) &
                  ((r1_en & (ex_wd == r1_addr)) | (r2_en & (ex_wd == r2_addr)));

  assign in_ready = ~rst & ~flush & ~hazard & (~out_valid_q | bus.out_ready);
  assign capture  = bus.in_valid & in_ready;

  // Next-state for the ID/EX register and the stall counter
  always_comb begin
    out_valid_d = out_valid_q;
    payload_d   = payload_q;
    stall_cnt_d = stall_cnt_q;
    if (rst) begin
      out_valid_d = 1'b0;
      payload_d   = '0;
      stall_cnt_d = '0;
    end else begin
      if (hazard && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      if (flush) begin
        out_valid_d = 1'b0;
      end else if (capture) begin
        out_valid_d     = 1'b1;
        payload_d.aluop = aluop_dec;
        payload_d.alusel = alusel_dec;
        payload_d.reg1  = op1;
        payload_d.reg2  = op2;
        payload_d.wd    = wd_dec;
        payload_d.wreg  = wreg_dec;
        payload_d.pc    = bus.pc_i;
        payload_d.inval = inval_dec;
      end else if (bus.out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers (reset folded into the next-state logic)
  always_ff @(posedge clk) begin
    out_valid_q <= out_valid_d;
    payload_q   <= payload_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign reg1_read_o        = r1_en;
  assign reg2_read_o        = r2_en;
  assign reg1_addr_o        = r1_addr;
  assign reg2_addr_o        = r2_addr;
  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.aluop_o        = payload_q.aluop;
  assign bus.alusel_o       = payload_q.alusel;
  assign bus.reg1_o         = payload_q.reg1;
  assign bus.reg2_o         = payload_q.reg2;
  assign bus.wd_o           = payload_q.wd;
  assign bus.wreg_o         = payload_q.wreg;
  assign bus.pc_o           = payload_q.pc;
  assign bus.inst_invalid_o = payload_q.inval;
  assign stall_cnt_o        = stall_cnt_q;

endmodule
